// File: rtl/rx_crc_pkg.sv
// rx_crc_pkg: shared state encoding and frame-check constants for the rx CRC sequencer.
package rx_crc_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, REPORT} state_t;
   localparam logic [31:0] RESIDUE = 32'hC704DD7B;
   localparam int MIN_LEN = 64;
   // Byte count carried by an eof word; the 3-bit field wraps 8 to 0.
   function automatic logic [3:0] eof_len(input logic [2:0] b);
      return (b == 3'd0) ? 4'd8 : {1'b0, b};
   endfunction
endpackage

// File: rtl/rx_crc_sequencer.sv
// rx_crc_sequencer: drives the 64-bit CRC-32 engine from a one-word input pipe and
// issues one status pulse per frame (crc check, length, runt, truncation).
module rx_crc_sequencer
   import rx_crc_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [63:0]      rx_data,
   input  logic             rx_valid,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic [2:0]       rx_eof_bytes,
   input  logic             rx_abort,
   output logic             crc_init,
   output logic             crc_calc,
   output logic             crc_dvalid,
   output logic [63:0]      crc_data,
   output logic [2:0]       crc_bits_more,
   input  logic [31:0]      crc_full,
   input  logic [31:0]      crc_part,
   output logic             stat_valid,
   output logic             stat_good,
   output logic [31:0]      stat_crc,
   output logic [LEN_W-1:0] stat_len,
   output logic             stat_runt,
   output logic             stat_trunc,
   output logic             proto_err
);
   state_t           r_state;
   logic [63:0]      r_p_data;
   logic             r_p_valid, r_p_eof;
   logic [2:0]       r_p_bytes, r_eob;
   logic [LEN_W-1:0] r_len;
   logic             w_start, w_trunc, w_take, w_dvalid, w_report;
   logic [LEN_W:0]   w_sum;
   logic [31:0]      w_res;

   // A sof in DRAIN would init the engine while it still absorbs the eof word, so it is refused.
   always_comb begin
      w_start  = rx_valid & rx_sof & ~rx_abort & (r_state != DRAIN);
      w_trunc  = w_start & (r_state == ACTIVE);
      w_take   = w_start | (rx_valid & ~rx_abort & (r_state == ACTIVE));
      w_dvalid = r_p_valid & ~w_trunc;
      w_report = ~rx_abort & (w_trunc | (r_state == REPORT));
      w_sum    = {1'b0, r_len} + (LEN_W+1)'(eof_len(r_p_eof ? r_p_bytes : 3'd0));
      w_res    = (r_eob == 3'd0) ? crc_full : crc_part;
   end

   assign crc_init      = w_start;
   assign crc_dvalid    = w_dvalid;
   assign crc_calc      = w_dvalid;
   assign crc_data      = r_p_data;
   assign crc_bits_more = r_p_eof ? r_p_bytes : 3'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_p_data   <= '0;
         r_p_valid  <= 1'b0;
         r_p_eof    <= 1'b0;
         r_p_bytes  <= '0;
         r_eob      <= '0;
         r_len      <= '0;
         stat_valid <= 1'b0;
         stat_good  <= 1'b0;
         stat_crc   <= '0;
         stat_len   <= '0;
         stat_runt  <= 1'b0;
         stat_trunc <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         r_p_valid <= w_take;
         r_p_eof   <= w_take & rx_eof;
         r_p_data  <= w_take ? rx_data : (rx_abort ? '0 : r_p_data);
         r_p_bytes <= w_take ? (rx_eof ? rx_eof_bytes : 3'd0) : (rx_abort ? 3'd0 : r_p_bytes);
         r_len     <= (w_start | rx_abort) ? '0 :
                      w_dvalid ? (w_sum[LEN_W] ? '1 : w_sum[LEN_W-1:0]) : r_len;
         r_eob     <= (r_state == DRAIN) ? r_p_bytes : r_eob;
         stat_valid <= w_report;
         proto_err  <= ~rx_abort & rx_valid &
                       (((r_state == IDLE) & rx_eof & ~rx_sof) | ((r_state == DRAIN) & rx_sof));
         if (w_report) begin
            stat_good  <= ~w_trunc & (w_res == RESIDUE);
            stat_crc   <= w_trunc ? crc_full : w_res;
            stat_len   <= r_len;
            stat_runt  <= r_len < LEN_W'(MIN_LEN);
            stat_trunc <= w_trunc;
         end
         r_state <= rx_abort ? IDLE :
                    w_start ? (rx_eof ? DRAIN : ACTIVE) :
                    ((r_state == ACTIVE) & rx_valid & rx_eof) ? DRAIN :
                    (r_state == DRAIN) ? REPORT :
                    (r_state == REPORT) ? IDLE : r_state;
      end
   end
endmodule
